uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  - UART receiver; the receive-side counterpart of uart_tx. Converts an 8N1 async serial line into bytes on clk.
//  - Feeds host-supplied plaintext/config bytes into the cipher datapath.
//  - Output interface mirrors uart_tx: 8-bit data plus a one-cycle strobe.
// PARAMETERS
//  - BIT_RATE  115200      line rate, bits/s
//  - CLK_HZ    16_000_000  clk frequency, Hz
//  - CYC_BIT   CLK_HZ/BIT_RATE (integer truncation; 138 at defaults)  derived localparam, clocks per bit
//  - CYC_HALF  CYC_BIT/2 (69 at defaults)                             derived localparam
// PORTS
//  - clk            in   1  system clock
//  - resetn         in   1  reset, asynchronous, active-low
//  - uart_rxd       in   1  async serial line; idles high
//  - uart_rx_en     in   1  receiver enable
//  - uart_rx_data   out  8  last good byte; held until next good byte
//  - uart_rx_valid  out  1  1-cycle strobe; uart_rx_data is new
//  - uart_rx_busy   out  1  high whenever state != IDLE
//  - uart_rx_ferr   out  1  1-cycle strobe: framing (or parity) error
// BEHAVIOUR
//  - Reset values: data=8'h00, valid=0, busy=0, ferr=0, state=IDLE, counters=0, sync FFs=1.
//  - Input synchroniser: 2 FFs reset to 1. All decisions use the synchronised bit (rxs).
//  - Bit counter: wraps 0..7. Cycle counter: width clog2(CYC_BIT), cleared on every state change.
//  - IDLE: on uart_rx_en=1 && rxs=0 -> START.
//  - START: when the cycle counter reaches CYC_HALF-1, sample rxs:
//    - rxs=0 -> DATA.
//    - rxs=1 -> glitch; return to IDLE with no strobe.
//  - DATA: sample rxs every CYC_BIT cycles (mid-bit), LSB first, into a shift reg. After bit 7 -> STOP (or PAR, see CONFIGURATION).
//  - STOP: sample at CYC_BIT.
//    - rxs=1 -> next cycle: uart_rx_data<=shift, valid=1 for exactly 1 cycle; -> IDLE.
//    - rxs=0 -> next cycle: ferr=1 for 1 cycle, data unchanged; -> WAIT_HI.
//  - WAIT_HI: stay until rxs=1, then -> IDLE (a break condition produces exactly one ferr).
//  - Latency: valid rises 1 clk after the stop-bit mid-sample, i.e. about 9.5 bit times + 3 clk after the start edge.
//  - IDLE is re-entered half a bit before the stop bit ends, so a back-to-back start bit is never missed.
//  - uart_rx_en=0 while not IDLE: abort to IDLE next cycle; no valid, no ferr; data unchanged.
//  - valid and ferr are mutually exclusive and never asserted in consecutive cycles for one frame.
//  - Async reset mid-frame: all state returns to reset values immediately. The frame in flight is discarded.
//  - No FIFO. Consumer must take data within about 1 frame time (overwritten on next valid).
// CONFIGURATION
//  - Macro UART_RX_PARITY_EN.
//  - Defined: frame is 8E1. State PAR follows DATA: sample at CYC_BIT, compare with ^shift (even parity).
//    - On mismatch, STOP still completes, then ferr=1 (no valid). Behaviour on a stop=0 error is unchanged (goes to WAIT_HI).
//    - uart_tx must be built with matching parity.
//  - Undefined: 8N1; PAR state and parity logic absent. Frame = 10 bits.
// TESTING
//  - Defaults. Send 0xA5 8N1 at 138 clk/bit -> one valid pulse; data=8'hA5; ferr never high; busy low after.
//  - Send 0x00 then 0xFF with zero idle gap -> two valid pulses; data 8'h00 then 8'hFF.
//  - Low glitch of 40 clk on idle line -> no valid, no ferr; busy high <=70 clk, then low.
//  - Frame 0x3C with stop bit=0, line held low 2000 clk, then high -> exactly one ferr pulse; data keeps prior value; next 0x5A received OK.
//  - Two mid-frame aborts, each followed by 0x81:
//    - resetn=0 at bit 4 of 0x77 -> outputs at reset values; 0x81 then received OK.
//    - uart_rx_en=0 at bit 4 of 0x77 -> aborted frame gives no strobes; 0x81 then received OK.
//  - UART_RX_PARITY_EN: send 0x07 with correct parity bit 1 -> valid, data=8'h07; same byte with parity bit 0 -> ferr, no valid.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver, counterpart of uart_tx.
//
// Turns an asynchronous serial line (8N1 by default) into bytes on clk.
// Each good byte is presented on uart_rx_data with a one-cycle
// uart_rx_valid strobe. A bad stop bit (or a bad parity bit) produces a
// one-cycle uart_rx_ferr strobe instead. There is no FIFO: the consumer
// must take each byte before the next one arrives.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined : 8N1 frame (start, 8 data LSB first, stop)
//   defined   : 8E1 frame (start, 8 data, even parity, stop)
//
// Parameters
//   BIT_RATE       line rate in bits/s
//   CLK_HZ         clk frequency in Hz
//
// Ports
//   clk            in   1  system clock
//   resetn         in   1  asynchronous active-low reset
//   uart_rxd       in   1  asynchronous serial line, idles high
//   uart_rx_en     in   1  receiver enable; low aborts any frame in flight
//   uart_rx_data   out  8  last good byte, held until the next good byte
//   uart_rx_valid  out  1  one-cycle strobe: uart_rx_data is new
//   uart_rx_busy   out  1  high while the receiver is not idle
//   uart_rx_ferr   out  1  one-cycle strobe: framing or parity error
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int BIT_RATE = 115200,
  parameter int CLK_HZ   = 16_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  input  logic       uart_rx_en,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       uart_rx_busy,
  output logic       uart_rx_ferr
);

  localparam int CYC_BIT  = CLK_HZ / BIT_RATE;
  localparam int CYC_HALF = CYC_BIT / 2;
  localparam int CW       = $clog2(CYC_BIT);

  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CYC_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CYC_HALF - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PAR     = 3'd3,
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic f_even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_cyc;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_rxs;
`ifdef UART_RX_PARITY_EN
  logic          r_par_err;
`endif

  assign w_rxs         = r_sync2;
  assign uart_rx_data  = r_data;
  assign uart_rx_valid = r_valid;
  assign uart_rx_ferr  = r_ferr;
  // Decoded straight from the state register, so it is glitch-free.
  assign uart_rx_busy  = (r_state != S_IDLE);

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM: frame sequencing, bit sampling and output strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_bit     <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      if ((r_state != S_IDLE) && !uart_rx_en) begin
        // Disable mid-frame: drop the frame silently, keep the last byte.
        r_state <= S_IDLE;
        r_cyc   <= '0;
        r_bit   <= 3'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cyc <= '0;
            r_bit <= 3'd0;
            if (uart_rx_en && !w_rxs) begin
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end

          S_START: begin
            // Re-check the start bit at its middle to reject short glitches.
            if (r_cyc == C_HALF_LAST) begin
              r_cyc <= '0;
              if (!w_rxs) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cyc <= r_cyc + 1'b1;
            end
          end

          S_DATA: begin
            // Counting starts at the start-bit middle, so every sample is mid-bit.
            if (r_cyc == C_BIT_LAST) begin
              r_cyc   <= '0;
              r_shift <= {w_rxs, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PAR;
`else
                r_state <= S_STOP;
`endif
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_cyc <= r_cyc + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          S_PAR: begin
            // Remember a parity mismatch; it is reported once the stop bit is in.
            if (r_cyc == C_BIT_LAST) begin
              r_cyc     <= '0;
              r_par_err <= (w_rxs != f_even_parity(r_shift));
              r_state   <= S_STOP;
            end else begin
              r_cyc <= r_cyc + 1'b1;
            end
          end
`endif

          S_STOP: begin
            // Leaving at mid-stop means the next start edge can't be missed.
            if (r_cyc == C_BIT_LAST) begin
              r_cyc <= '0;
              if (w_rxs) begin
                r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                if (r_par_err) begin
                  r_ferr <= 1'b1;
                end else begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end
`else
                r_data  <= r_shift;
                r_valid <= 1'b1;
`endif
              end else begin
                r_ferr  <= 1'b1;
                r_state <= S_WAIT_HI;
              end
            end else begin
              r_cyc <= r_cyc + 1'b1;
            end
          end

          S_WAIT_HI: begin
            // A held-low line (break) must return high before a new frame.
            r_cyc <= '0;
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WAIT_HI;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_bit   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CYC_BIT = 16_000_000 / 115200;  // 138

  logic       clk;
  logic       resetn;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_busy;
  logic       uart_rx_ferr;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  uart_rx dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rxd      (uart_rxd),
    .uart_rx_en    (uart_rx_en),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_busy  (uart_rx_busy),
    .uart_rx_ferr  (uart_rx_ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && (uart_rx_valid || uart_rx_ferr)) begin
      if (uart_rx_valid && uart_rx_ferr) begin
        chk("valid_ferr_exclusive", 32'(1), 32'(0));
      end
      if (q_exp.size() == 0) begin
        chk("unexpected_strobe", 32'({uart_rx_valid, uart_rx_ferr}), 32'(0));
      end else begin
        e = q_exp.pop_front();
        chk("strobe_is_ferr", 32'(uart_rx_ferr), 32'(e.err));
        if (!e.err) begin
          chk("rx_data", 32'(uart_rx_data), 32'(e.data));
        end
      end
    end
  end

  // Drive one frame. cut >= 0 stops half-way through frame bit index 'cut'
  // (0 = start bit, 1..8 = data bits). Line is left at the last driven level.
  task automatic send_frame(input logic [7:0] d, input logic par_bit,
                            input logic stop_bit, input int cut);
    logic [10:0] fr;
    int          n;
`ifdef UART_RX_PARITY_EN
    fr = {stop_bit, par_bit, d, 1'b0};
    n  = 11;
`else
    fr = {1'b0, stop_bit, d, 1'b0};
    n  = 10;
    if (par_bit) begin end
`endif
    for (int i = 0; i < n; i++) begin
      uart_rxd = fr[i];
      if (cut >= 0 && i == cut) begin
        repeat (CYC_BIT / 2) @(negedge clk);
        return;
      end
      repeat (CYC_BIT) @(negedge clk);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.data = d;
    q_exp.push_back(e);
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.err  = 1'b1;
    e.data = 8'h00;
    q_exp.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (q_exp.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(q_exp.size()), 32'(0));
  endtask

  initial begin
    int busy_cnt;

    resetn     = 1'b0;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(uart_rx_data),  32'(8'h00));
    chk("rst_valid", 32'(uart_rx_valid), 32'(0));
    chk("rst_busy",  32'(uart_rx_busy),  32'(0));
    chk("rst_ferr",  32'(uart_rx_ferr),  32'(0));
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    wait_drain("drain_a5");
    repeat (5) @(negedge clk);
    chk("busy_after_a5", 32'(uart_rx_busy), 32'(0));

    // Back-to-back, no idle gap
    expect_byte(8'h00);
    send_frame(8'h00, 1'b0, 1'b1, -1);
    expect_byte(8'hFF);
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    wait_drain("drain_00_ff");
    repeat (CYC_BIT) @(negedge clk);

    // Short low glitch on an idle line
    uart_rxd = 1'b0;
    repeat (40) @(negedge clk);
    uart_rxd = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (uart_rx_busy) busy_cnt++;
    end
    chk("glitch_busy_seen", 32'(busy_cnt > 0), 32'(1));
    chk("glitch_busy_le70", 32'(busy_cnt <= 70), 32'(1));
    chk("glitch_busy_end", 32'(uart_rx_busy), 32'(0));

    // Bad stop bit followed by a long break
    expect_ferr();
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    repeat (2000) @(negedge clk);
    chk("break_busy", 32'(uart_rx_busy), 32'(1));
    uart_rxd = 1'b1;
    repeat (CYC_BIT) @(negedge clk);
    wait_drain("drain_break");
    chk("break_data_kept", 32'(uart_rx_data), 32'(8'hFF));
    chk("break_idle", 32'(uart_rx_busy), 32'(0));
    expect_byte(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    wait_drain("drain_5a");
    repeat (CYC_BIT) @(negedge clk);

    // Reset in the middle of bit 4
    send_frame(8'h77, 1'b0, 1'b1, 5);
    resetn = 1'b0;
    #1;
    chk("midrst_data",  32'(uart_rx_data),  32'(8'h00));
    chk("midrst_valid", 32'(uart_rx_valid), 32'(0));
    chk("midrst_busy",  32'(uart_rx_busy),  32'(0));
    chk("midrst_ferr",  32'(uart_rx_ferr),  32'(0));
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (2 * CYC_BIT) @(negedge clk);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    wait_drain("drain_81_a");
    repeat (CYC_BIT) @(negedge clk);

    // Disable in the middle of bit 4
    send_frame(8'h77, 1'b0, 1'b1, 5);
    uart_rx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_abort_busy", 32'(uart_rx_busy), 32'(0));
    uart_rxd = 1'b1;
    repeat (12 * CYC_BIT) @(negedge clk);
    chk("en_abort_data", 32'(uart_rx_data), 32'(8'h81));
    uart_rx_en = 1'b1;
    repeat (CYC_BIT) @(negedge clk);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    wait_drain("drain_81_b");
    repeat (CYC_BIT) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones -> parity bit 1
    expect_byte(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    wait_drain("drain_par_ok");
    expect_ferr();
    send_frame(8'h07, 1'b0, 1'b1, -1);
    wait_drain("drain_par_bad");
    chk("par_bad_data_kept", 32'(uart_rx_data), 32'(8'h07));
    repeat (CYC_BIT) @(negedge clk);
`endif

    chk("final_busy", 32'(uart_rx_busy), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
